// File: rtl/slink_gpio_deserializer.sv
// Receive-side deserializer: gathers IO_DATA_WIDTH-bit beats into PAR_DATA_WIDTH-bit words on a valid/ready port.
// Define SLINK_GPIO_DESER_PARITY_EN to expect a trailing even-parity beat per word (reported on rx_par_err).
//
// state   | meaning
// S_IDLE  | no word in progress, waiting for rx_ser_io_en
// S_SHIFT | beats of a word arriving, r_cnt is the next beat index
module slink_gpio_deserializer #(
    parameter int PAR_DATA_WIDTH = 8,
    parameter int IO_DATA_WIDTH  = 2
) (
    input  logic                      serial_clk,
    input  logic                      serial_reset,
    input  logic                      rx_ser_io_en,
    input  logic [IO_DATA_WIDTH-1:0]  rx_ser_data,
    output logic [PAR_DATA_WIDTH-1:0] rx_par_data,
    output logic                      rx_par_valid,
    input  logic                      rx_par_ready,
    output logic                      rx_frame_err,
    output logic                      rx_overrun,
    input  logic                      clr_overrun,
    output logic                      rx_par_err,
    output logic [15:0]               rx_word_cnt
);

    localparam int BEATS = PAR_DATA_WIDTH / IO_DATA_WIDTH;
`ifdef SLINK_GPIO_DESER_PARITY_EN
    localparam int PAR_BEATS = 1;
`else
    localparam int PAR_BEATS = 0;
`endif
    localparam int TOT_BEATS = BEATS + PAR_BEATS;
    localparam int CNT_W     = (TOT_BEATS > 1) ? $clog2(TOT_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(TOT_BEATS - 1);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t                    r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [PAR_DATA_WIDTH-1:0] r_shift;
    logic [PAR_DATA_WIDTH-1:0] r_data;
    logic                      r_valid;
    logic                      r_frame_err;
    logic                      r_overrun;
    logic [15:0]               r_word_cnt;

    logic [PAR_DATA_WIDTH-1:0] w_shift_nxt;
    logic [PAR_DATA_WIDTH-1:0] w_word;
    logic                      w_complete;
    logic                      w_accept;
    logic                      w_load;
    logic                      w_drop;

    // The parity beat (index BEATS) matches no slot, so it never disturbs the data bits.
    always_comb begin
        w_shift_nxt = r_shift;
        for (int k = 0; k < BEATS; k++) begin
            if (r_cnt == CNT_W'(k)) begin
                w_shift_nxt[k*IO_DATA_WIDTH +: IO_DATA_WIDTH] = rx_ser_data;
            end
        end
    end

`ifdef SLINK_GPIO_DESER_PARITY_EN
    logic r_par_err;
    logic w_par_err;

    assign w_word     = r_shift;
    assign w_par_err  = (^r_shift) != rx_ser_data[0];
    assign rx_par_err = r_par_err;
`else
    assign w_word     = w_shift_nxt;
    assign rx_par_err = 1'b0;
`endif

    assign w_complete = rx_ser_io_en && (r_cnt == LAST_BEAT);
    assign w_accept   = r_valid && rx_par_ready;
    assign w_load     = w_complete && (!r_valid || w_accept);
    assign w_drop     = w_complete && r_valid && !rx_par_ready;

    always_ff @(posedge serial_clk or posedge serial_reset) begin
        if (serial_reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_word_cnt  <= '0;
`ifdef SLINK_GPIO_DESER_PARITY_EN
            r_par_err   <= 1'b0;
`endif
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (rx_ser_io_en) begin
                        r_shift <= w_shift_nxt;
                        if (TOT_BEATS == 1) begin
                            r_cnt <= '0;
                        end else begin
                            r_cnt   <= CNT_W'(1);
                            r_state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    if (rx_ser_io_en) begin
                        r_shift <= w_shift_nxt;
                        r_cnt   <= (r_cnt == LAST_BEAT) ? '0 : r_cnt + CNT_W'(1);
                    end else begin
                        if (r_cnt != '0) begin
                            r_frame_err <= 1'b1;
                            r_shift     <= '0;
                        end
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
            endcase

            if (w_load) begin
                r_data    <= w_word;
                r_valid   <= 1'b1;
`ifdef SLINK_GPIO_DESER_PARITY_EN
                r_par_err <= w_par_err;
`endif
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end

            // A dropped word outranks a simultaneous clear so no overrun is ever lost.
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clr_overrun) begin
                r_overrun <= 1'b0;
            end

            if (w_accept) begin
                r_word_cnt <= r_word_cnt + 16'd1;
            end
        end
    end

    assign rx_par_data  = r_data;
    assign rx_par_valid = r_valid;
    assign rx_frame_err = r_frame_err;
    assign rx_overrun   = r_overrun;
    assign rx_word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_slink_gpio_deserializer.sv
// Directed bench for slink_gpio_deserializer (8-bit words, 2-bit beats); parity beats added when
// SLINK_GPIO_DESER_PARITY_EN is defined.
module tb_slink_gpio_deserializer;

    logic        serial_clk = 1'b0;
    logic        serial_reset;
    logic        rx_ser_io_en;
    logic [1:0]  rx_ser_data;
    logic [7:0]  rx_par_data;
    logic        rx_par_valid;
    logic        rx_par_ready;
    logic        rx_frame_err;
    logic        rx_overrun;
    logic        clr_overrun;
    logic        rx_par_err;
    logic [15:0] rx_word_cnt;

    int n_vec = 0;
    int n_err = 0;

`ifdef SLINK_GPIO_DESER_PARITY_EN
    localparam bit TB_PAR = 1'b1;
`else
    localparam bit TB_PAR = 1'b0;
`endif

    slink_gpio_deserializer #(.PAR_DATA_WIDTH(8), .IO_DATA_WIDTH(2)) dut (
        .serial_clk   (serial_clk),
        .serial_reset (serial_reset),
        .rx_ser_io_en (rx_ser_io_en),
        .rx_ser_data  (rx_ser_data),
        .rx_par_data  (rx_par_data),
        .rx_par_valid (rx_par_valid),
        .rx_par_ready (rx_par_ready),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun),
        .clr_overrun  (clr_overrun),
        .rx_par_err   (rx_par_err),
        .rx_word_cnt  (rx_word_cnt)
    );

    always #5 serial_clk = ~serial_clk;

    // Apply inputs, let one rising edge sample them, return 1ns later.
    task automatic step(input logic en, input logic [1:0] d);
        rx_ser_io_en = en;
        rx_ser_data  = d;
        @(posedge serial_clk);
        #1;
    endtask

    // ready/clr given for the final beat only; io_en is left high afterwards.
    task automatic send_word(input logic [7:0] w, input bit bad_par, input bit rdy_last, input bit clr_last);
        for (int k = 0; k < 4; k++) begin
            if (k == 3 && !TB_PAR) begin
                rx_par_ready = rdy_last;
                clr_overrun  = clr_last;
            end
            step(1'b1, w[k*2 +: 2]);
        end
        if (TB_PAR) begin
            rx_par_ready = rdy_last;
            clr_overrun  = clr_last;
            step(1'b1, {1'b0, (^w) ^ bad_par});
        end
        clr_overrun = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        n_vec++;
        if ({rx_par_valid, rx_frame_err, rx_overrun, rx_par_err} !== 4'b0000) begin
            $display("FAIL reset_flags: got %b exp 0000", {rx_par_valid, rx_frame_err, rx_overrun, rx_par_err});
            n_err++;
        end
        n_vec++;
        if (rx_par_data !== 8'h00 || rx_word_cnt !== 16'd0) begin
            $display("FAIL reset_data: got data %h cnt %0d exp 00 / 0", rx_par_data, rx_word_cnt);
            n_err++;
        end
        @(posedge serial_clk);
        #1;
        serial_reset = 1'b0;
    endtask

    task automatic test_basic;
        rx_par_ready = 1'b1;
        send_word(8'h36, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if (rx_par_valid !== 1'b1 || rx_par_data !== 8'h36) begin
            $display("FAIL basic_word: got v=%b d=%h exp v=1 d=36", rx_par_valid, rx_par_data);
            n_err++;
        end
        step(1'b0, 2'b00);
        n_vec++;
        if (rx_par_valid !== 1'b0 || rx_word_cnt !== 16'd1) begin
            $display("FAIL basic_accept: got v=%b cnt=%0d exp v=0 cnt=1", rx_par_valid, rx_word_cnt);
            n_err++;
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] bytes [10];
        bit         err_seen;
        err_seen = 1'b0;
        rx_par_ready = 1'b1;
        for (int i = 0; i < 10; i++) bytes[i] = 8'($urandom);
        for (int i = 0; i < 10; i++) begin
            send_word(bytes[i], 1'b0, 1'b1, 1'b0);
            n_vec++;
            if (rx_par_valid !== 1'b1 || rx_par_data !== bytes[i]) begin
                $display("FAIL b2b_word%0d: got v=%b d=%h exp v=1 d=%h", i, rx_par_valid, rx_par_data, bytes[i]);
                n_err++;
            end
            if (rx_frame_err !== 1'b0 || rx_overrun !== 1'b0) err_seen = 1'b1;
        end
        step(1'b0, 2'b00);
        if (rx_frame_err !== 1'b0) err_seen = 1'b1;
        n_vec++;
        if (err_seen || rx_word_cnt !== 16'd11 || rx_par_valid !== 1'b0) begin
            $display("FAIL b2b_end: got err=%b cnt=%0d v=%b exp err=0 cnt=11 v=0", err_seen, rx_word_cnt, rx_par_valid);
            n_err++;
        end
    endtask

    task automatic test_frame_err;
        rx_par_ready = 1'b1;
        step(1'b1, 2'b01);
        step(1'b1, 2'b10);
        step(1'b0, 2'b00);
        n_vec++;
        if (rx_frame_err !== 1'b1 || rx_par_valid !== 1'b0) begin
            $display("FAIL frame_pulse: got fe=%b v=%b exp fe=1 v=0", rx_frame_err, rx_par_valid);
            n_err++;
        end
        step(1'b0, 2'b00);
        n_vec++;
        if (rx_frame_err !== 1'b0) begin
            $display("FAIL frame_once: got fe=%b exp 0", rx_frame_err);
            n_err++;
        end
        send_word(8'hA5, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if (rx_par_valid !== 1'b1 || rx_par_data !== 8'hA5) begin
            $display("FAIL frame_next: got v=%b d=%h exp v=1 d=a5", rx_par_valid, rx_par_data);
            n_err++;
        end
        step(1'b0, 2'b00);
        n_vec++;
        if (rx_word_cnt !== 16'd12) begin
            $display("FAIL frame_cnt: got %0d exp 12", rx_word_cnt);
            n_err++;
        end
    endtask

    task automatic test_overrun;
        rx_par_ready = 1'b0;
        send_word(8'h11, 1'b0, 1'b0, 1'b0);
        send_word(8'h22, 1'b0, 1'b0, 1'b0);
        step(1'b0, 2'b00);
        n_vec++;
        if (rx_par_valid !== 1'b1 || rx_par_data !== 8'h11 || rx_overrun !== 1'b1) begin
            $display("FAIL ovr_hold: got v=%b d=%h ovr=%b exp v=1 d=11 ovr=1", rx_par_valid, rx_par_data, rx_overrun);
            n_err++;
        end
        rx_par_ready = 1'b1;
        step(1'b0, 2'b00);
        n_vec++;
        if (rx_par_valid !== 1'b0 || rx_word_cnt !== 16'd13 || rx_overrun !== 1'b1) begin
            $display("FAIL ovr_accept: got v=%b cnt=%0d ovr=%b exp v=0 cnt=13 ovr=1", rx_par_valid, rx_word_cnt, rx_overrun);
            n_err++;
        end
        clr_overrun = 1'b1;
        step(1'b0, 2'b00);
        clr_overrun = 1'b0;
        n_vec++;
        if (rx_overrun !== 1'b0) begin
            $display("FAIL ovr_clear: got %b exp 0", rx_overrun);
            n_err++;
        end
        rx_par_ready = 1'b0;
        send_word(8'h33, 1'b0, 1'b0, 1'b0);
        send_word(8'h44, 1'b0, 1'b0, 1'b1);
        n_vec++;
        if (rx_overrun !== 1'b1 || rx_par_data !== 8'h33) begin
            $display("FAIL ovr_set_wins: got ovr=%b d=%h exp ovr=1 d=33", rx_overrun, rx_par_data);
            n_err++;
        end
        rx_par_ready = 1'b1;
        clr_overrun  = 1'b1;
        step(1'b0, 2'b00);
        clr_overrun  = 1'b0;
        n_vec++;
        if (rx_overrun !== 1'b0 || rx_word_cnt !== 16'd14) begin
            $display("FAIL ovr_drain: got ovr=%b cnt=%0d exp ovr=0 cnt=14", rx_overrun, rx_word_cnt);
            n_err++;
        end
    endtask

    task automatic test_accept_and_complete;
        rx_par_ready = 1'b0;
        send_word(8'h5C, 1'b0, 1'b0, 1'b0);
        send_word(8'hC3, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if (rx_par_valid !== 1'b1 || rx_par_data !== 8'hC3 || rx_overrun !== 1'b0 || rx_word_cnt !== 16'd15) begin
            $display("FAIL coincide: got v=%b d=%h ovr=%b cnt=%0d exp v=1 d=c3 ovr=0 cnt=15",
                     rx_par_valid, rx_par_data, rx_overrun, rx_word_cnt);
            n_err++;
        end
        step(1'b0, 2'b00);
        n_vec++;
        if (rx_par_valid !== 1'b0 || rx_word_cnt !== 16'd16) begin
            $display("FAIL coincide_drain: got v=%b cnt=%0d exp v=0 cnt=16", rx_par_valid, rx_word_cnt);
            n_err++;
        end
    endtask

`ifdef SLINK_GPIO_DESER_PARITY_EN
    task automatic test_parity;
        rx_par_ready = 1'b1;
        send_word(8'h07, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if (rx_par_valid !== 1'b1 || rx_par_data !== 8'h07 || rx_par_err !== 1'b0) begin
            $display("FAIL parity_good: got v=%b d=%h pe=%b exp v=1 d=07 pe=0", rx_par_valid, rx_par_data, rx_par_err);
            n_err++;
        end
        send_word(8'h07, 1'b1, 1'b1, 1'b0);
        n_vec++;
        if (rx_par_valid !== 1'b1 || rx_par_err !== 1'b1) begin
            $display("FAIL parity_bad: got v=%b pe=%b exp v=1 pe=1", rx_par_valid, rx_par_err);
            n_err++;
        end
        step(1'b0, 2'b00);
        for (int k = 0; k < 4; k++) step(1'b1, 2'b11);
        step(1'b0, 2'b00);
        n_vec++;
        if (rx_frame_err !== 1'b1 || rx_par_valid !== 1'b0) begin
            $display("FAIL parity_frame: got fe=%b v=%b exp fe=1 v=0", rx_frame_err, rx_par_valid);
            n_err++;
        end
    endtask
`endif

    task automatic test_reset_midword;
        rx_par_ready = 1'b1;
        step(1'b1, 2'b11);
        step(1'b1, 2'b11);
        #2;
        serial_reset = 1'b1;
        #1;
        n_vec++;
        if (rx_word_cnt !== 16'd0 || rx_par_valid !== 1'b0 || rx_frame_err !== 1'b0) begin
            $display("FAIL rst_async: got cnt=%0d v=%b fe=%b exp 0/0/0", rx_word_cnt, rx_par_valid, rx_frame_err);
            n_err++;
        end
        rx_ser_io_en = 1'b0;
        @(posedge serial_clk);
        #1;
        serial_reset = 1'b0;
        step(1'b0, 2'b00);
        n_vec++;
        if (rx_frame_err !== 1'b0) begin
            $display("FAIL rst_no_fe: got %b exp 0", rx_frame_err);
            n_err++;
        end
        send_word(8'h5A, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if (rx_par_valid !== 1'b1 || rx_par_data !== 8'h5A) begin
            $display("FAIL rst_next: got v=%b d=%h exp v=1 d=5a", rx_par_valid, rx_par_data);
            n_err++;
        end
        step(1'b0, 2'b00);
        n_vec++;
        if (rx_word_cnt !== 16'd1) begin
            $display("FAIL rst_cnt: got %0d exp 1", rx_word_cnt);
            n_err++;
        end
    endtask

    initial begin
        serial_reset = 1'b1;
        rx_ser_io_en = 1'b0;
        rx_ser_data  = 2'b00;
        rx_par_ready = 1'b0;
        clr_overrun  = 1'b0;
        test_reset;
        test_basic;
        test_back_to_back;
        test_frame_err;
        test_overrun;
        test_accept_and_complete;
`ifdef SLINK_GPIO_DESER_PARITY_EN
        test_parity;
`endif
        test_reset_midword;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
